// File: rtl/loader_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | loader_pkg : shared state and error-code encodings for rom_loader    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package loader_pkg;

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] LEN  = 3'd1;
    localparam logic [2:0] DATA = 3'd2;
    localparam logic [2:0] CSUM = 3'd3;
    localparam logic [2:0] DONE = 3'd4;
    localparam logic [2:0] ERR  = 3'd5;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_CSUM = 2'd1;
    localparam logic [1:0] ERR_LEN  = 2'd2;
    localparam logic [1:0] ERR_TMO  = 2'd3;

endpackage
`default_nettype wire

// File: rtl/rom_loader_word_assembler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | word_assembler : packs a byte stream into little-endian 32-bit words |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module word_assembler (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [1:0]  r_idx;
    logic [23:0] r_bytes;

    // Bytes enter at the top and shift down, so the first byte ends up as the LSB.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_idx   <= 2'd0;
            r_bytes <= 24'd0;
        end else if (byte_valid) begin
            r_idx   <= r_idx + 2'd1;
            r_bytes <= {byte_data, r_bytes[23:8]};
        end
    end

    assign word_valid = byte_valid && !clear && (r_idx == 2'd3);
    assign word       = {byte_data, r_bytes};

endmodule
`default_nettype wire

// File: rtl/rom_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rom_loader : UART byte-stream boot loader for the instruction ROM    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module rom_loader
    import loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MAX_WORDS = 4096,
    parameter int unsigned TIMEOUT   = 1_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        rx_valid_i,
    input  logic [7:0]  rx_data_i,
    output logic        w_en,
    output logic [31:0] w_addr_o,
    output logic [31:0] w_data_o,
    output logic        hold_o,
    output logic        done_o,
    output logic        err_o,
    output logic [1:0]  err_code_o
);

    localparam int unsigned C_CNT_W = $clog2(MAX_WORDS + 1);
    localparam int unsigned C_TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [C_CNT_W-1:0] C_CNT_ONE  = C_CNT_W'(1);
    localparam logic [C_TMR_W-1:0] C_TMR_ONE  = C_TMR_W'(1);
    localparam logic [C_TMR_W-1:0] C_TMR_LAST = C_TMR_W'(TIMEOUT - 1);

    logic [2:0]         r_state;
    logic [C_CNT_W-1:0] r_word_cnt;
    logic [C_CNT_W-1:0] r_len;
    logic [7:0]         r_csum;
    logic [C_TMR_W-1:0] r_timer;
    logic [1:0]         r_err_pend;

    logic        w_in_frame;
    logic        w_asm_valid;
    logic        w_asm_clear;
    logic        w_word_valid;
    logic [31:0] w_word;

    assign w_in_frame  = (r_state == LEN) || (r_state == DATA) || (r_state == CSUM);
    assign w_asm_valid = rx_valid_i && ((r_state == LEN) || (r_state == DATA));
    assign w_asm_clear = (r_state == IDLE);

    word_assembler u_asm (
        .clk        (clk),
        .rst        (rst),
        .clear      (w_asm_clear),
        .byte_valid (w_asm_valid),
        .byte_data  (rx_data_i),
        .word_valid (w_word_valid),
        .word       (w_word)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_word_cnt <= '0;
            r_len      <= '0;
            r_csum     <= 8'd0;
            r_timer    <= '0;
            r_err_pend <= ERR_NONE;
            w_en       <= 1'b0;
            w_addr_o   <= BASE_ADDR;
            w_data_o   <= 32'd0;
            hold_o     <= 1'b0;
            done_o     <= 1'b0;
            err_o      <= 1'b0;
            err_code_o <= ERR_NONE;
        end else begin
            w_en   <= 1'b0;
            done_o <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start_i) begin
                        r_state    <= LEN;
                        r_word_cnt <= '0;
                        r_csum     <= 8'd0;
                        r_timer    <= '0;
                        r_err_pend <= ERR_NONE;
                        hold_o     <= 1'b1;
                        err_o      <= 1'b0;
                        err_code_o <= ERR_NONE;
                    end
                end
                LEN: begin
                    // Bound check uses the full 32-bit field so large counts cannot alias.
                    if (w_word_valid) begin
                        r_len <= w_word[C_CNT_W-1:0];
                        if (w_word > 32'(MAX_WORDS)) begin
                            r_state    <= ERR;
                            r_err_pend <= ERR_LEN;
                        end else if (w_word == 32'd0) begin
                            r_state <= CSUM;
                        end else begin
                            r_state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (rx_valid_i) begin
                        r_csum <= r_csum + rx_data_i;
                        if (w_word_valid) begin
                            w_en       <= 1'b1;
                            w_addr_o   <= BASE_ADDR + 32'({r_word_cnt, 2'b00});
                            w_data_o   <= w_word;
                            r_word_cnt <= r_word_cnt + C_CNT_ONE;
                            if ((r_word_cnt + C_CNT_ONE) == r_len) begin
                                r_state <= CSUM;
                            end
                        end
                    end
                end
                CSUM: begin
                    if (rx_valid_i) begin
                        if (rx_data_i == r_csum) begin
                            r_state <= DONE;
                        end else begin
                            r_state    <= ERR;
                            r_err_pend <= ERR_CSUM;
                        end
                    end
                end
                DONE: begin
                    done_o  <= 1'b1;
                    hold_o  <= 1'b0;
                    r_state <= IDLE;
                end
                ERR: begin
                    err_o      <= 1'b1;
                    err_code_o <= r_err_pend;
                    hold_o     <= 1'b0;
                    r_state    <= IDLE;
                end
                default: r_state <= IDLE;
            endcase

            // Frame transitions above all need a byte, so a timeout never collides with them.
            if (w_in_frame) begin
                if (rx_valid_i) begin
                    r_timer <= '0;
                end else if (r_timer == C_TMR_LAST) begin
                    r_state    <= ERR;
                    r_err_pend <= ERR_TMO;
                end else begin
                    r_timer <= r_timer + C_TMR_ONE;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rom_loader.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_rom_loader : scoreboard bench for rom_loader                      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_rom_loader;

    localparam logic [31:0] C_BASE = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic        rx_valid_i;
    logic [7:0]  rx_data_i;
    logic        w_en;
    logic [31:0] w_addr_o;
    logic [31:0] w_data_o;
    logic        hold_o;
    logic        done_o;
    logic        err_o;
    logic [1:0]  err_code_o;

    rom_loader #(
        .BASE_ADDR (C_BASE),
        .MAX_WORDS (4096),
        .TIMEOUT   (16)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .rx_valid_i (rx_valid_i),
        .rx_data_i  (rx_data_i),
        .w_en       (w_en),
        .w_addr_o   (w_addr_o),
        .w_data_o   (w_data_o),
        .hold_o     (hold_o),
        .done_o     (done_o),
        .err_o      (err_o),
        .err_code_o (err_code_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    wr_t        sb[$];
    wr_t        mon_exp;
    int         cyc     = 0;
    int         n_total = 0;
    int         n_pass  = 0;
    logic [7:0] exp_csum;

    always @(posedge clk) cyc <= cyc + 1;

    // Every write must match the oldest expected entry and land in the cycle it was predicted for.
    always @(negedge clk) begin
        if (w_en === 1'b1) begin
            n_total++;
            if (sb.size() == 0) begin
                $display("FAIL write_unexpected: got addr=%h data=%h, need no write", w_addr_o, w_data_o);
            end else begin
                mon_exp = sb.pop_front();
                if (w_addr_o !== mon_exp.addr || w_data_o !== mon_exp.data || cyc != mon_exp.cyc)
                    $display("FAIL write_value: got addr=%h data=%h cyc=%0d, need addr=%h data=%h cyc=%0d",
                             w_addr_o, w_data_o, cyc, mon_exp.addr, mon_exp.data, mon_exp.cyc);
                else
                    n_pass++;
            end
        end else if (sb.size() != 0 && sb[0].cyc <= cyc) begin
            n_total++;
            mon_exp = sb.pop_front();
            $display("FAIL write_missing: got no w_en, need addr=%h data=%h", mon_exp.addr, mon_exp.data);
        end
    end

    task automatic send_byte(input logic [7:0] b);
        rx_valid_i = 1'b1;
        rx_data_i  = b;
        @(posedge clk);
        #1;
        rx_valid_i = 1'b0;
        rx_data_i  = 8'h00;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start;
        start_i = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
    endtask

    task automatic send_len(input logic [31:0] n);
        for (int i = 0; i < 4; i++) send_byte(n[8*i +: 8]);
    endtask

    task automatic send_word(input logic [31:0] w, input int k);
        for (int i = 0; i < 4; i++) begin
            send_byte(w[8*i +: 8]);
            exp_csum = exp_csum + w[8*i +: 8];
        end
        sb.push_back('{addr: C_BASE + 32'(k) * 32'd4, data: w, cyc: cyc});
    endtask

    task automatic test_reset;
        rst = 1'b1; start_i = 1'b0; rx_valid_i = 1'b0; rx_data_i = 8'h00;
        idle(2);
        n_total++;
        if ({w_en, w_addr_o, w_data_o, hold_o, done_o, err_o, err_code_o} !== {1'b0, C_BASE, 32'h0, 5'b0})
            $display("FAIL reset_values: got w_en=%b addr=%h data=%h hold=%b done=%b err=%b code=%0d, need all zero/base",
                     w_en, w_addr_o, w_data_o, hold_o, done_o, err_o, err_code_o);
        else n_pass++;
        rst = 1'b0;
        idle(2);
    endtask

    task automatic test_two_word;
        exp_csum = 8'h00;
        n_total++;
        if (hold_o !== 1'b0) $display("FAIL hold_before_start: got %b, need 0", hold_o);
        else n_pass++;
        pulse_start();
        n_total++;
        if (hold_o !== 1'b1) $display("FAIL hold_rise: got %b, need 1", hold_o);
        else n_pass++;
        send_len(32'd2);
        send_word(32'h1234_5678, 0);
        send_word(32'hDEAD_BEEF, 1);
        send_byte(exp_csum);
        n_total++;
        if ({done_o, hold_o} !== 2'b01) $display("FAIL done_early: got done,hold=%b%b, need 01", done_o, hold_o);
        else n_pass++;
        idle(1);
        n_total++;
        if ({done_o, hold_o, err_o, err_code_o} !== 5'b10000)
            $display("FAIL done_pulse: got done,hold,err,code=%b%b%b%0d, need 1000", done_o, hold_o, err_o, err_code_o);
        else n_pass++;
        idle(1);
        n_total++;
        if (done_o !== 1'b0) $display("FAIL done_one_cycle: got %b, need 0", done_o);
        else n_pass++;
        n_total++;
        if (sb.size() != 0) $display("FAIL two_word_writes: got %0d pending, need 0", sb.size());
        else n_pass++;
    endtask

    task automatic test_zero_len;
        pulse_start();
        send_len(32'd0);
        send_byte(8'h00);
        idle(1);
        n_total++;
        if ({done_o, hold_o, err_o, err_code_o} !== 5'b10000)
            $display("FAIL zero_len_done: got done,hold,err,code=%b%b%b%0d, need 1000", done_o, hold_o, err_o, err_code_o);
        else n_pass++;
        idle(2);
    endtask

    task automatic test_bad_csum;
        exp_csum = 8'h00;
        pulse_start();
        send_len(32'd2);
        send_word(32'h1234_5678, 0);
        send_word(32'hDEAD_BEEF, 1);
        send_byte(exp_csum + 8'd1);
        idle(1);
        n_total++;
        if ({done_o, hold_o, err_o, err_code_o} !== 5'b00101)
            $display("FAIL csum_err: got done,hold,err,code=%b%b%b%0d, need 0011", done_o, hold_o, err_o, err_code_o);
        else n_pass++;
        idle(3);
        n_total++;
        if ({err_o, err_code_o} !== 3'b101) $display("FAIL csum_err_sticky: got err,code=%b%0d, need 11", err_o, err_code_o);
        else n_pass++;
    endtask

    task automatic test_oversize;
        pulse_start();
        n_total++;
        if ({hold_o, err_o, err_code_o} !== 4'b1000)
            $display("FAIL start_clears_err: got hold,err,code=%b%b%0d, need 100", hold_o, err_o, err_code_o);
        else n_pass++;
        send_len(32'h0000_1001);
        n_total++;
        if ({hold_o, err_o} !== 2'b10) $display("FAIL len_err_early: got hold,err=%b%b, need 10", hold_o, err_o);
        else n_pass++;
        idle(1);
        n_total++;
        if ({done_o, hold_o, err_o, err_code_o} !== 5'b00110)
            $display("FAIL len_err: got done,hold,err,code=%b%b%b%0d, need 0012", done_o, hold_o, err_o, err_code_o);
        else n_pass++;
        for (int i = 0; i < 8; i++) send_byte(8'(8'hA0 + i));
        n_total++;
        if ({hold_o, err_o, err_code_o} !== 4'b0110)
            $display("FAIL len_err_ignore: got hold,err,code=%b%b%0d, need 012", hold_o, err_o, err_code_o);
        else n_pass++;
        // High bits set, low bits zero: must not alias to an empty frame.
        pulse_start();
        send_len(32'h0100_0000);
        idle(1);
        n_total++;
        if ({hold_o, err_o, err_code_o} !== 4'b0110)
            $display("FAIL len_err_wide: got hold,err,code=%b%b%0d, need 012", hold_o, err_o, err_code_o);
        else n_pass++;
    endtask

    task automatic test_timeout;
        exp_csum = 8'h00;
        pulse_start();
        send_len(32'd2);
        send_word(32'h1234_5678, 0);
        send_byte(8'hEF);
        idle(15);
        send_byte(8'hBE);
        idle(16);
        n_total++;
        if ({hold_o, err_o} !== 2'b10) $display("FAIL timeout_byte_wins: got hold,err=%b%b, need 10", hold_o, err_o);
        else n_pass++;
        idle(1);
        n_total++;
        if ({hold_o, err_o, err_code_o} !== 4'b0111)
            $display("FAIL timeout_err: got hold,err,code=%b%b%0d, need 013", hold_o, err_o, err_code_o);
        else n_pass++;
        n_total++;
        if (sb.size() != 0) $display("FAIL timeout_writes: got %0d pending, need 0", sb.size());
        else n_pass++;
    endtask

    task automatic test_reset_restart;
        pulse_start();
        send_len(32'd1);
        send_byte(8'h11);
        send_byte(8'h22);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        n_total++;
        if ({w_en, w_addr_o, w_data_o, hold_o, done_o, err_o, err_code_o} !== {1'b0, C_BASE, 32'h0, 5'b0})
            $display("FAIL mid_reset: got w_en=%b addr=%h data=%h hold=%b done=%b err=%b code=%0d, need all zero/base",
                     w_en, w_addr_o, w_data_o, hold_o, done_o, err_o, err_code_o);
        else n_pass++;
        idle(4);
        exp_csum = 8'h00;
        pulse_start();
        send_len(32'd1);
        pulse_start();
        send_word(32'hCAFE_F00D, 0);
        send_byte(exp_csum);
        idle(1);
        n_total++;
        if ({done_o, hold_o, err_o, err_code_o} !== 5'b10000)
            $display("FAIL restart_done: got done,hold,err,code=%b%b%b%0d, need 1000", done_o, hold_o, err_o, err_code_o);
        else n_pass++;
        idle(2);
        n_total++;
        if (sb.size() != 0) $display("FAIL restart_writes: got %0d pending, need 0", sb.size());
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_two_word();
        test_zero_len();
        test_bad_csum();
        test_oversize();
        test_timeout();
        test_reset_restart();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000ns, need finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
